// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
// master: byte source / memory side; slave: the loader itself.
interface instr_mem_loader_if;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        im_we_o;
    logic [31:0] im_addr_o;
    logic [31:0] im_data_o;

    modport master (
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  im_we_o,
        input  im_addr_o,
        input  im_data_o
    );

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output im_we_o,
        output im_addr_o,
        output im_data_o
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Run-time program loader: packs a big-endian byte stream into 32-bit
// words, writes them to instruction memory and holds the CPU in reset
// until the whole program is in place.
// Ports: clk_i/rst_i (sync, active-low), start_i/word_count_i to begin a
// load, bus (byte stream in, memory write out), cpu_rst_o (active-low CPU
// reset), busy_o/done_o/err_o status, chk_o byte checksum of last load.
module instr_mem_loader #(
    parameter int WORDS = 32,
    parameter int AW    = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [AW:0]         word_count_i,
    instr_mem_loader_if.slave   bus,
    output logic                cpu_rst_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [7:0]          chk_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    localparam logic [AW:0] MAX_CNT = (AW+1)'(WORDS);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t        state_q,    state_d;
    logic [AW:0]   cnt_q,      cnt_d;
    logic [AW-1:0] word_idx_q, word_idx_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    // Only the first three bytes need storing; the fourth goes
    // straight into the write data.
    logic [23:0]   word_q,     word_d;
    logic [7:0]    chk_q,      chk_d;
    logic          ready_q,    ready_d;
    logic          we_q,       we_d;
    logic [31:0]   addr_q,     addr_d;
    logic [31:0]   data_q,     data_d;
    logic          cpu_rst_q,  cpu_rst_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;

    logic          xfer;
    logic          legal;
    logic          last;

    assign xfer  = (state_q == LOAD) && bus.byte_valid_i && ready_q;
    assign legal = (word_count_i != '0) && (word_count_i <= MAX_CNT);
    // Compared at full width so a WORDS-long load never relies on wrap.
    assign last  = ({1'b0, word_idx_q} == (cnt_q - ONE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        chk_d      = chk_q;
        ready_d    = ready_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        cpu_rst_d  = cpu_rst_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    if (legal) begin
                        cnt_d      = word_count_i;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        word_d     = '0;
                        chk_d      = '0;
                        cpu_rst_d  = 1'b0;
                        done_d     = 1'b0;
                        busy_d     = 1'b1;
                        ready_d    = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    word_d     = {word_q[15:0], bus.byte_i};
                    chk_d      = chk_q + bus.byte_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Registered write strobe lines up with WRITE.
                        we_d    = 1'b1;
                        addr_d  = 32'({word_idx_q, 2'b00});
                        data_d  = {word_q, bus.byte_i};
                        ready_d = 1'b0;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (last) begin
                    busy_d    = 1'b0;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    word_idx_d = word_idx_q + AW'(1);
                    byte_cnt_d = '0;
                    ready_d    = 1'b1;
                    state_d    = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            chk_q      <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cpu_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            chk_q      <= chk_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.byte_ready_o = ready_q;
    assign bus.im_we_o      = we_q;
    assign bus.im_addr_o    = addr_q;
    assign bus.im_data_o    = data_q;
    assign cpu_rst_o        = cpu_rst_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign chk_o            = chk_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: single/multi-word loads, throttled
// stream, illegal counts, full-depth load, reset mid-load and restart.
module tb_instr_mem_loader;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [5:0] word_count_i;
    logic       cpu_rst_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [7:0] chk_o;

    instr_mem_loader_if ifc ();

    instr_mem_loader #(.WORDS(32), .AW(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .word_count_i (word_count_i),
        .bus          (ifc.slave),
        .cpu_rst_o    (cpu_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .chk_o        (chk_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always @(posedge clk_i) begin
        if (ifc.im_we_o) begin
            wa_q.push_back(ifc.im_addr_o);
            wd_q.push_back(ifc.im_data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic [5:0] cnt);
        start_i      = 1'b1;
        word_count_i = cnt;
        step();
        start_i      = 1'b0;
    endtask

    task automatic send(input bit toggle);
        int idx = 0;
        int c   = 0;
        bit x;
        while (idx < tx_q.size() && c < 2000) begin
            ifc.byte_i       = tx_q[idx];
            ifc.byte_valid_i = toggle ? (c % 2 == 1) : 1'b1;
            x = ifc.byte_valid_i && ifc.byte_ready_o;
            step();
            if (x) idx++;
            c++;
        end
        ifc.byte_valid_i = 1'b0;
        if (idx < tx_q.size())
            check("send_timeout", idx, tx_q.size());
    endtask

    logic [7:0]  sum;
    logic [31:0] w;

    initial begin
        rst_i            = 1'b0;
        start_i          = 1'b0;
        word_count_i     = '0;
        ifc.byte_i       = '0;
        ifc.byte_valid_i = 1'b0;
        step();
        step();
        check("rst_ready", ifc.byte_ready_o, 0);
        check("rst_we",    ifc.im_we_o, 0);
        check("rst_addr",  ifc.im_addr_o, 0);
        check("rst_data",  ifc.im_data_o, 0);
        check("rst_cpu",   cpu_rst_o, 0);
        check("rst_flags", {busy_o, done_o, err_o}, 0);
        check("rst_chk",   chk_o, 0);
        rst_i = 1'b1;
        step();

        // one word, back-to-back
        start(6'd1);
        check("t1_ready", ifc.byte_ready_o, 1);
        check("t1_busy", busy_o, 1);
        tx_q = '{8'h20, 8'h01, 8'h00, 8'h05};
        send(1'b0);
        check("t1_we",   ifc.im_we_o, 1);
        check("t1_addr", ifc.im_addr_o, 32'h0);
        check("t1_data", ifc.im_data_o, 32'h20010005);
        check("t1_cpu_pre", cpu_rst_o, 0);
        step();
        check("t1_cpu",  cpu_rst_o, 1);
        check("t1_done", done_o, 1);
        check("t1_busy_end", busy_o, 0);
        check("t1_chk",  chk_o, 8'h26);
        check("t1_nwr",  wa_q.size(), 1);

        // three words, throttled stream
        wa_q.delete();
        wd_q.delete();
        start(6'd3);
        check("t2_cpu_drop", cpu_rst_o, 0);
        check("t2_done_drop", done_o, 0);
        tx_q.delete();
        sum = 0;
        for (int i = 0; i < 12; i++) begin
            tx_q.push_back(8'h11 + 8'(i));
            sum = sum + (8'h11 + 8'(i));
        end
        send(1'b1);
        step();
        check("t2_nwr", wa_q.size(), 3);
        if (wa_q.size() == 3) begin
            check("t2_a0", wa_q[0], 32'h0);
            check("t2_a1", wa_q[1], 32'h4);
            check("t2_a2", wa_q[2], 32'h8);
            check("t2_d0", wd_q[0], 32'h11121314);
            check("t2_d1", wd_q[1], 32'h15161718);
            check("t2_d2", wd_q[2], 32'h191A1B1C);
        end
        check("t2_done", done_o, 1);
        check("t2_chk", chk_o, sum);

        // illegal counts from IDLE
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        start(6'd0);
        check("t3_err0", err_o, 1);
        check("t3_idle0", {busy_o, ifc.byte_ready_o, cpu_rst_o}, 0);
        step();
        check("t3_errclr", err_o, 0);
        start(6'd33);
        check("t3_err33", err_o, 1);
        check("t3_idle33", {busy_o, ifc.byte_ready_o, cpu_rst_o}, 0);
        step();

        // full-depth load with an ignored start mid-load
        wa_q.delete();
        wd_q.delete();
        start(6'd32);
        tx_q.delete();
        sum = 0;
        for (int i = 0; i < 128; i++) begin
            tx_q.push_back(8'(i * 5 + 1));
            sum = sum + 8'(i * 5 + 1);
        end
        tx_q = tx_q[0:9];
        send(1'b0);
        start(6'd0);
        check("t4_noerr", err_o, 0);
        check("t4_busy", busy_o, 1);
        tx_q.delete();
        for (int i = 10; i < 128; i++)
            tx_q.push_back(8'(i * 5 + 1));
        send(1'b0);
        step();
        check("t4_nwr", wa_q.size(), 32);
        if (wa_q.size() == 32) begin
            w = {8'(124*5+1), 8'(125*5+1), 8'(126*5+1), 8'(127*5+1)};
            check("t4_alast", wa_q[31], 32'd124);
            check("t4_dlast", wd_q[31], w);
            w = {8'(40*5+1), 8'(41*5+1), 8'(42*5+1), 8'(43*5+1)};
            check("t4_d10", wd_q[10], w);
        end
        check("t4_done", done_o, 1);
        check("t4_chk", chk_o, sum);
        ifc.byte_i       = 8'hFF;
        ifc.byte_valid_i = 1'b1;
        step();
        ifc.byte_valid_i = 1'b0;
        check("t4_done_rdy", ifc.byte_ready_o, 0);
        check("t4_done_chk", chk_o, sum);
        check("t4_done_nwr", wa_q.size(), 32);
        start(6'd33);
        check("t4_err_done", err_o, 1);
        check("t4_keep", {cpu_rst_o, done_o}, 2'b11);
        step();
        start(6'd1);
        check("t4_restart", {cpu_rst_o, done_o, busy_o}, 3'b001);

        // reset in the middle of a two-word load
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        wa_q.delete();
        wd_q.delete();
        start(6'd2);
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send(1'b0);
        rst_i = 1'b0;
        step();
        check("t5_nwr", wa_q.size(), 1);
        check("t5_rst_bus", {ifc.byte_ready_o, ifc.im_we_o}, 0);
        check("t5_rst_addr", ifc.im_addr_o, 0);
        check("t5_rst_data", ifc.im_data_o, 0);
        check("t5_rst_st", {cpu_rst_o, busy_o, done_o, err_o}, 0);
        check("t5_rst_chk", chk_o, 0);
        rst_i = 1'b1;
        step();
        start(6'd1);
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(1'b0);
        check("t5_data", ifc.im_data_o, 32'hAABBCCDD);
        check("t5_addr", ifc.im_addr_o, 32'h0);
        step();
        check("t5_done", {cpu_rst_o, done_o}, 2'b11);
        check("t5_chk", chk_o, 8'h0E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
